// File: rtl/spi_txn_arbiter.sv
// rtl/spi_txn_arbiter.sv - two-requester round-robin arbiter framing byte transfers onto one SPI master
module spi_txn_arbiter #(
    parameter int GAP_CYCLES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic [1:0] len0,
    input  logic [1:0] len1,
    input  logic [7:0] wdata0,
    input  logic [7:0] wdata1,
    output logic [1:0] grant,
    output logic [1:0] data_ack,
    output logic [1:0] xfer_done,
    input  logic       spi_tx_ready,
    input  logic       spi_done,
    output logic       spi_start,
    output logic [7:0] spi_tx_data,
    output logic       spi_ss_n
);

    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GW-1:0] GAP_LAST = (GAP_CYCLES > 0) ? GW'(GAP_CYCLES - 1) : '0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_WAIT_RDY,
        ST_WAIT_DONE,
        ST_GAP
    } state_t;

    state_t          r_state;
    logic [1:0]      r_remaining;
    logic [GW-1:0]   r_gap_cnt;
    // Index of the last granted requester; during a frame it is also the owner.
    logic            r_last;

    logic            w_winner;
    logic [1:0]      w_len;
    logic [7:0]      w_wdata;

    // Round-robin pick: a lone request wins, a tie goes to the requester not granted last.
    always_comb begin
        w_winner = ~r_last;
        if (req == 2'b01) begin
            w_winner = 1'b0;
        end else if (req == 2'b10) begin
            w_winner = 1'b1;
        end
        w_len   = w_winner ? len1 : len0;
        w_wdata = r_last ? wdata1 : wdata0;
    end

    // Frame sequencer: grant, per-byte load/start/done handshake, inter-frame gap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_remaining <= 2'd0;
            r_gap_cnt   <= '0;
            r_last      <= 1'b1;
            grant       <= 2'b00;
            data_ack    <= 2'b00;
            xfer_done   <= 2'b00;
            spi_start   <= 1'b0;
            spi_tx_data <= 8'h00;
            spi_ss_n    <= 1'b1;
        end else begin
            data_ack  <= 2'b00;
            xfer_done <= 2'b00;
            spi_start <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (req != 2'b00) begin
                        grant       <= w_winner ? 2'b10 : 2'b01;
                        r_last      <= w_winner;
                        r_remaining <= w_len;
                        spi_ss_n    <= 1'b0;
                        r_state     <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    spi_tx_data <= w_wdata;
                    data_ack    <= r_last ? 2'b10 : 2'b01;
                    r_state     <= ST_WAIT_RDY;
                end
                ST_WAIT_RDY: begin
                    if (spi_tx_ready) begin
                        spi_start <= 1'b1;
                        r_state   <= ST_WAIT_DONE;
                    end
                end
                ST_WAIT_DONE: begin
                    if (spi_done) begin
                        if (r_remaining != 2'd0) begin
                            r_remaining <= r_remaining - 2'd1;
                            r_state     <= ST_LOAD;
                        end else begin
                            spi_ss_n  <= 1'b1;
                            grant     <= 2'b00;
                            xfer_done <= r_last ? 2'b10 : 2'b01;
                            r_gap_cnt <= '0;
                            r_state   <= (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
                        end
                    end
                end
                ST_GAP: begin
                    // Requests arriving here stay pending on req and are served from IDLE.
                    if (r_gap_cnt == GAP_LAST) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
